// File: rtl/kernel_load_ctrl.sv
// kernel_load_ctrl: round-robin arbiter and sequencer for the shared bank of
// per-kernel parameter ROMs used by the convolution engines.
//
// One requester owns the ROM bank at a time. The controller strobes the
// selected ROM, waits out its read latency, then pulses param_valid with
// grant/rom_sel held so the datapath can mux the ROM's registered read_out
// bus to the owner. An out-of-range kernel index ends in a param_err pulse
// and never touches a ROM.
//
// Handshake (requester side): req[i] is a level request. req[i] and its
// req_kidx slice must be held stable until the cycle of param_valid or
// param_err with grant[i] set, and req[i] must drop in the following cycle.
// A req still high when the controller is back in IDLE is a new request.
// Requests are sampled only in IDLE.
//
// Optional feature: define KLC_SKIP_RELOAD_EN to remember which ROMs have
// already been read since reset. A repeat load of such a ROM skips the
// strobe and the latency and reports valid two cycles after sampling.
// With the macro undefined every transaction reads the ROM.

module kernel_load_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int NUM_KERNELS = 6,
  parameter int ROM_LAT     = 1,
  parameter int KW          = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*KW-1:0]  req_kidx,
  output logic [NUM_KERNELS-1:0] rom_read,
  output logic [KW-1:0]          rom_sel,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   param_valid,
  output logic                   param_err
);

  // Pointer and wait-counter widths; both are at least one bit wide.
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  // The pointer resets to the last requester so requester 0 wins first.
  localparam logic [PW-1:0] PTR_RST  = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ROM_LAT - 1);

  // Number of ROMs, one bit wider than a kernel index, for range checks.
  localparam logic [KW:0] NK_EXT = (KW + 1)'(NUM_KERNELS);

  // Sequencer states.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;

  // Arbitration results, meaningful in IDLE only.
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [KW-1:0] win_kidx;
  logic          win_ok;
  logic          win_skip;

  // Properties of the latched index, used in READ.
  logic          sel_ok;
  logic          sel_skip;

  // True when a kernel index addresses an existing ROM.
  function automatic logic kidx_in_range(input logic [KW-1:0] k);
    return {1'b0, k} < NK_EXT;
  endfunction

  // One-hot ROM select; all zero for an out-of-range index.
  function automatic logic [NUM_KERNELS-1:0] kidx_onehot(input logic [KW-1:0] k);
    logic [NUM_KERNELS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_KERNELS; i++) begin
      oh[i] = (k == KW'(i));
    end
    return oh;
  endfunction

  // Round-robin search: first requester above the pointer, wrapping around,
  // so the last winner has the lowest priority next time.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  // Kernel index of the winning requester and its range check.
  always_comb begin
    win_kidx = req_kidx[int'(win_idx)*KW +: KW];
    win_ok   = kidx_in_range(win_kidx);
    sel_ok   = kidx_in_range(rom_sel);
  end

`ifdef KLC_SKIP_RELOAD_EN
  // One bit per ROM: set once that ROM has delivered valid data.
  logic [NUM_KERNELS-1:0] loaded;

  // Record each completed load; reset forgets everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded <= '0;
    end else if (state == S_VALID) begin
      loaded <= loaded | kidx_onehot(rom_sel);
    end
  end

  // A loaded ROM still holds its data on read_out, so no re-read is needed.
  always_comb begin
    win_skip = |(loaded & kidx_onehot(win_kidx));
    sel_skip = |(loaded & kidx_onehot(rom_sel));
  end
`else
  // Every transaction reads its ROM.
  always_comb begin
    win_skip = 1'b0;
    sel_skip = 1'b0;
  end
`endif

  // Sequencer: all outputs are registered and change only on the clock edge.
  // The strobe is issued on the IDLE->READ edge so that it is high during
  // READ; the wait counter then counts the remaining ROM_LAT-1 cycles and
  // param_valid is set on the edge entering VALID.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= PTR_RST;
      cnt         <= '0;
      rom_read    <= '0;
      rom_sel     <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      param_valid <= 1'b0;
      param_err   <= 1'b0;
    end else begin
      // Strobes and status pulses last exactly one cycle.
      rom_read    <= '0;
      param_valid <= 1'b0;
      param_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant   <= NUM_REQ'(1) << win_idx;
            rom_sel <= win_kidx;
            busy    <= 1'b1;
            ptr     <= win_idx;
            state   <= S_READ;
            if (win_ok && !win_skip) begin
              rom_read <= kidx_onehot(win_kidx);
            end
          end
        end
        S_READ: begin
          if (!sel_ok) begin
            param_err <= 1'b1;
            state     <= S_ERR;
          end else if (sel_skip || (CNT_LOAD == '0)) begin
            // Single-cycle ROM, or data already on the ROM output.
            param_valid <= 1'b1;
            state       <= S_VALID;
          end else begin
            cnt   <= CNT_LOAD;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Leaving on a count of 1 puts VALID exactly ROM_LAT cycles
          // after the strobe cycle.
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) begin
            param_valid <= 1'b1;
            state       <= S_VALID;
          end
        end
        S_VALID, S_ERR: begin
          // rom_sel stays put so the ROM output mux keeps its selection.
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// tb_kernel_load_ctrl: bench for kernel_load_ctrl.
// DUT a: ROM_LAT=1, driven from a table of per-cycle vectors.
// DUT b: ROM_LAT=3, driven by hand-written multi-cycle sequences.
// Every param_valid/param_err is matched against a queue of expected
// {err, grant, rom_sel} records pushed when the request is driven.
// Honors KLC_SKIP_RELOAD_EN when the bench is built with it.

module tb_kernel_load_ctrl;

`ifdef KLC_SKIP_RELOAD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [1:0] req_a, req_b;
  logic [2:0] k0_a, k1_a, k0_b, k1_b;

  logic [5:0] rom_read_a, rom_read_b;
  logic [2:0] rom_sel_a, rom_sel_b;
  logic [1:0] grant_a, grant_b;
  logic       busy_a, busy_b, pv_a, pv_b, pe_a, pe_b;

  kernel_load_ctrl #(.NUM_REQ(2), .NUM_KERNELS(6), .ROM_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .req_kidx({k1_a, k0_a}),
    .rom_read(rom_read_a), .rom_sel(rom_sel_a), .grant(grant_a),
    .busy(busy_a), .param_valid(pv_a), .param_err(pe_a)
  );

  kernel_load_ctrl #(.NUM_REQ(2), .NUM_KERNELS(6), .ROM_LAT(3)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .req_kidx({k1_b, k0_b}),
    .rom_read(rom_read_b), .rom_sel(rom_sel_b), .grant(grant_b),
    .busy(busy_b), .param_valid(pv_b), .param_err(pe_b)
  );

  logic [13:0] out_a, out_b;
  assign out_a = {rom_read_a, grant_a, rom_sel_a, busy_a, pv_a, pe_a};
  assign out_b = {rom_read_b, grant_b, rom_sel_b, busy_b, pv_b, pe_b};

  // Packs an expected output word in the same layout as out_a/out_b.
  function automatic logic [13:0] o(input logic [5:0] rr, input logic [1:0] g,
                                    input logic [2:0] s, input logic b,
                                    input logic pv, input logic pe);
    return {rr, g, s, b, pv, pe};
  endfunction

  // Scoreboard record: {err, grant, rom_sel}.
  function automatic logic [5:0] sb(input logic err, input logic [1:0] g,
                                    input logic [2:0] s);
    return {err, g, s};
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [5:0] exp_qa[$];
  logic [5:0] exp_qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pop an expectation whenever a DUT reports a result.
  always @(negedge clk) begin
    if (pv_a || pe_a) begin
      if (exp_qa.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL sb_a: got unexpected result %h expected none", {pe_a, grant_a, rom_sel_a});
      end else begin
        chk("sb_a", {26'd0, pe_a, grant_a, rom_sel_a}, {26'd0, exp_qa.pop_front()});
      end
    end
    if (pv_b || pe_b) begin
      if (exp_qb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL sb_b: got unexpected result %h expected none", {pe_b, grant_b, rom_sel_b});
      end else begin
        chk("sb_b", {26'd0, pe_b, grant_b, rom_sel_b}, {26'd0, exp_qb.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [2:0]  k0;
    logic [2:0]  k1;
    logic        txn;
    logic [5:0]  sbv;
    logic [13:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] q, input logic [2:0] k0,
                     input logic [2:0] k1, input logic txn, input logic [5:0] sbv,
                     input logic [13:0] exp);
    vec_t v;
    v.rst = r; v.req = q; v.k0 = k0; v.k1 = k1;
    v.txn = txn; v.sbv = sbv; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] rr;
    rst_a = 1'b1; req_a = '0; k0_a = '0; k1_a = '0;
    rst_b = 1'b1; req_b = '0; k0_b = '0; k1_b = '0;

    // Row: inputs for one cycle, outputs expected just after that edge.
    // Reset.
    add(1, 2'b00, 0, 0, 0, 0, o(6'b000000, 2'b00, 0, 0, 0, 0));
    add(1, 2'b00, 0, 0, 0, 0, o(6'b000000, 2'b00, 0, 0, 0, 0));
    // Single request, kidx 3.
    add(0, 2'b01, 3, 0, 1, sb(0, 2'b01, 3), o(6'b001000, 2'b01, 3, 1, 0, 0));
    add(0, 2'b01, 3, 0, 0, 0, o(6'b000000, 2'b01, 3, 1, 1, 0));
    add(0, 2'b00, 3, 0, 0, 0, o(6'b000000, 2'b00, 3, 0, 0, 0));
    add(0, 2'b00, 3, 0, 0, 0, o(6'b000000, 2'b00, 3, 0, 0, 0));
    // Bad index 6 from requester 1: no strobe, error two cycles after sampling.
    add(0, 2'b10, 0, 6, 1, sb(1, 2'b10, 6), o(6'b000000, 2'b10, 6, 1, 0, 0));
    add(0, 2'b10, 0, 6, 0, 0, o(6'b000000, 2'b10, 6, 1, 0, 1));
    add(0, 2'b00, 0, 6, 0, 0, o(6'b000000, 2'b00, 6, 0, 0, 0));
    // Contention, req held at 11: grants alternate, strobes 3 cycles apart.
    add(0, 2'b11, 1, 4, 1, sb(0, 2'b01, 1), o(6'b000010, 2'b01, 1, 1, 0, 0));
    add(0, 2'b11, 1, 4, 0, 0, o(6'b000000, 2'b01, 1, 1, 1, 0));
    add(0, 2'b11, 1, 4, 0, 0, o(6'b000000, 2'b00, 1, 0, 0, 0));
    rr = SKIP ? 6'b000000 : 6'b010000;
    add(0, 2'b11, 1, 4, 1, sb(0, 2'b10, 4), o(6'b010000, 2'b10, 4, 1, 0, 0));
    add(0, 2'b11, 1, 4, 0, 0, o(6'b000000, 2'b10, 4, 1, 1, 0));
    add(0, 2'b11, 1, 4, 0, 0, o(6'b000000, 2'b00, 4, 0, 0, 0));
    rr = SKIP ? 6'b000000 : 6'b000010;
    add(0, 2'b11, 1, 4, 1, sb(0, 2'b01, 1), o(rr, 2'b01, 1, 1, 0, 0));
    add(0, 2'b00, 1, 4, 0, 0, o(6'b000000, 2'b01, 1, 1, 1, 0));
    add(0, 2'b00, 1, 4, 0, 0, o(6'b000000, 2'b00, 1, 0, 0, 0));
    rr = SKIP ? 6'b000000 : 6'b010000;
    add(0, 2'b11, 1, 4, 1, sb(0, 2'b10, 4), o(rr, 2'b10, 4, 1, 0, 0));
    add(0, 2'b00, 1, 4, 0, 0, o(6'b000000, 2'b10, 4, 1, 1, 0));
    add(0, 2'b00, 1, 4, 0, 0, o(6'b000000, 2'b00, 4, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst; req_a = vecs[i].req;
      k0_a = vecs[i].k0;   k1_a = vecs[i].k1;
      if (vecs[i].txn) exp_qa.push_back(vecs[i].sbv);
      tick();
      chk($sformatf("vec%0d", i), {18'd0, out_a}, {18'd0, vecs[i].exp});
    end

    // ---- ROM_LAT=3: latency, grant stable, kidx change ignored ----
    rst_b = 1'b1; tick();
    chk("b_reset", {18'd0, out_b}, 32'd0);
    rst_b = 1'b0; req_b = 2'b10; k1_b = 3'd5;
    exp_qb.push_back(sb(0, 2'b10, 5));
    tick(); chk("b_strobe", {18'd0, out_b}, {18'd0, o(6'b100000, 2'b10, 5, 1, 0, 0)});
    k1_b = 3'd0;
    tick(); chk("b_wait1", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b10, 5, 1, 0, 0)});
    tick(); chk("b_wait2", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b10, 5, 1, 0, 0)});
    tick(); chk("b_valid", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b10, 5, 1, 1, 0)});
    req_b = 2'b00;
    tick(); chk("b_idle", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b00, 5, 0, 0, 0)});

    // ---- reset in WAIT aborts; pointer returns to requester 0 first ----
    req_b = 2'b01; k0_b = 3'd2;
    tick(); chk("b_strobe2", {18'd0, out_b}, {18'd0, o(6'b000100, 2'b01, 2, 1, 0, 0)});
    tick(); chk("b_inwait", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b01, 2, 1, 0, 0)});
    rst_b = 1'b1;
    tick(); chk("b_abort", {18'd0, out_b}, 32'd0);
    rst_b = 1'b0; req_b = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("b_quiet", {18'd0, out_b}, 32'd0);
    end
    req_b = 2'b11; k0_b = 3'd1; k1_b = 3'd3;
    exp_qb.push_back(sb(0, 2'b01, 1));
    tick(); chk("b_rr_rst", {18'd0, out_b}, {18'd0, o(6'b000010, 2'b01, 1, 1, 0, 0)});
    tick(); tick();
    tick(); chk("b_rr_valid", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b01, 1, 1, 1, 0)});
    req_b = 2'b10;
    tick(); chk("b_rr_idle", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b00, 1, 0, 0, 0)});
    exp_qb.push_back(sb(0, 2'b10, 3));
    tick(); chk("b_rr_next", {18'd0, out_b}, {18'd0, o(6'b001000, 2'b10, 3, 1, 0, 0)});
    tick(); tick();
    tick(); chk("b_rr_valid2", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b10, 3, 1, 1, 0)});
    req_b = 2'b00;
    tick(); chk("b_rr_idle2", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b00, 3, 0, 0, 0)});

    // ---- reload of the same kernel (skip path when enabled) ----
    req_b = 2'b01; k0_b = 3'd2;
    exp_qb.push_back(sb(0, 2'b01, 2));
    tick(); chk("b_load1", {18'd0, out_b}, {18'd0, o(6'b000100, 2'b01, 2, 1, 0, 0)});
    tick(); tick();
    tick(); chk("b_load1_valid", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b01, 2, 1, 1, 0)});
    req_b = 2'b00;
    tick();
    req_b = 2'b01;
    exp_qb.push_back(sb(0, 2'b01, 2));
    if (SKIP) begin
      tick(); chk("b_reload", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b01, 2, 1, 0, 0)});
      tick(); chk("b_reload_valid", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b01, 2, 1, 1, 0)});
    end else begin
      tick(); chk("b_reload", {18'd0, out_b}, {18'd0, o(6'b000100, 2'b01, 2, 1, 0, 0)});
      tick(); tick();
      tick(); chk("b_reload_valid", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b01, 2, 1, 1, 0)});
    end
    req_b = 2'b00;
    tick();
    rst_b = 1'b1; tick();
    rst_b = 1'b0; req_b = 2'b01;
    exp_qb.push_back(sb(0, 2'b01, 2));
    tick(); chk("b_load_after_rst", {18'd0, out_b}, {18'd0, o(6'b000100, 2'b01, 2, 1, 0, 0)});
    tick(); tick();
    tick(); chk("b_load_after_rst_valid", {18'd0, out_b}, {18'd0, o(6'b000000, 2'b01, 2, 1, 1, 0)});
    req_b = 2'b00;
    tick(); tick();

    // ---- report ----
    chk("sb_a_drained", exp_qa.size(), 32'd0);
    chk("sb_b_drained", exp_qb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
